// File: rtl/mem_io_responder.sv
// Byte-wide memory-bus responder: 2^ADDR_WIDTH bytes of RAM plus an I/O window at
// mem_a[17:16]==2'b11 holding UART RX/TX, a cycle counter and the program-stop flag.
module mem_io_responder #(
    parameter int ADDR_WIDTH = 17,
    parameter int TX_DEPTH   = 8
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [31:0] mem_a,
    input  logic [7:0]  mem_dout,
    input  logic        mem_wr,
    output logic [7:0]  mem_din,
    output logic        io_buffer_full,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        sim_stop,
    output logic        tx_overflow
);
    localparam int RAM_BYTES = 1 << ADDR_WIDTH;
    localparam int PTR_W     = $clog2(TX_DEPTH);
    localparam int CNT_W     = PTR_W + 1;

    localparam logic [2:0] OFF_UART  = 3'd0;
    localparam logic [2:0] OFF_CNT_0 = 3'd4;
    localparam logic [2:0] OFF_CNT_1 = 3'd5;
    localparam logic [2:0] OFF_CNT_2 = 3'd6;
    localparam logic [2:0] OFF_CNT_3 = 3'd7;

    logic [7:0]       ram [RAM_BYTES];
    logic [7:0]       ram_rd_q;
    logic [7:0]       tx_mem [TX_DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [31:0]      cycle_cnt_q, cycle_cnt_d;
    logic [31:0]      snap_q, snap_d;
    logic [7:0]       io_rd_q, io_rd_d;
    logic             rd_sel_ram_q, rd_sel_ram_d;
    logic             rx_ready_q, rx_ready_d;
    logic             sim_stop_q, sim_stop_d;
    logic             tx_overflow_q, tx_overflow_d;

    logic             is_io;
    logic [2:0]       io_off;
    logic             bus_rd;
    logic             bus_wr;
    logic             ram_we;
    logic             ram_re;
    logic             push_req;
    logic [7:0]       push_data;
    logic             push;
    logic             pop;
    logic             fifo_full;
    logic             unused_addr_bits;

    assign unused_addr_bits = ^mem_a[31:18];

    always_comb begin
        is_io  = (mem_a[17:16] == 2'b11);
        io_off = mem_a[2:0];
        bus_rd = rdy_in && !mem_wr;
        bus_wr = rdy_in && mem_wr;
        ram_we = bus_wr && !is_io;
        ram_re = bus_rd && !is_io;
    end

    // Synchronous-read RAM with no reset so it maps onto block RAM.
    always_ff @(posedge clk_in) begin
        if (ram_we) begin
            ram[mem_a[ADDR_WIDTH-1:0]] <= mem_dout;
        end
        if (ram_re) begin
            ram_rd_q <= ram[mem_a[ADDR_WIDTH-1:0]];
        end
    end

    // Read side: the I/O byte is captured here and mem_din selects between it and
    // the RAM output, so reset forces mem_din to zero through the select flop.
    always_comb begin
        rd_sel_ram_d = rd_sel_ram_q;
        io_rd_d      = io_rd_q;
        rx_ready_d   = 1'b0;
        snap_d       = snap_q;
        if (bus_rd) begin
            if (is_io) begin
                rd_sel_ram_d = 1'b0;
                case (io_off)
                    OFF_UART: begin
                        if (rx_valid) begin
                            io_rd_d    = rx_data;
                            rx_ready_d = 1'b1;
                        end else begin
                            io_rd_d = 8'h00;
                        end
                    end
                    OFF_CNT_0: begin
                        snap_d  = cycle_cnt_q;
                        io_rd_d = cycle_cnt_q[7:0];
                    end
                    OFF_CNT_1: io_rd_d = snap_q[15:8];
                    OFF_CNT_2: io_rd_d = snap_q[23:16];
                    OFF_CNT_3: io_rd_d = snap_q[31:24];
                    default:   io_rd_d = 8'h00;
                endcase
            end else begin
                rd_sel_ram_d = 1'b1;
            end
        end
    end

    // Write side and TX FIFO bookkeeping; a pop at full frees the slot a push reuses.
    always_comb begin
        push_req   = 1'b0;
        push_data  = mem_dout;
        sim_stop_d = sim_stop_q;
        if (bus_wr && is_io) begin
            if (io_off == OFF_UART) begin
                push_req = (mem_dout != 8'h00);
            end else if (io_off == OFF_CNT_0) begin
                push_req   = 1'b1;
                push_data  = 8'h00;
                sim_stop_d = 1'b1;
            end
        end

        pop           = (count_q != '0) && tx_ready;
        fifo_full     = (count_q == CNT_W'(TX_DEPTH));
        push          = push_req && (!fifo_full || pop);
        tx_overflow_d = tx_overflow_q || (push_req && fifo_full && !pop);

        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end

        cycle_cnt_d = rdy_in ? cycle_cnt_q + 32'd1 : cycle_cnt_q;
    end

    always_ff @(posedge clk_in) begin
        if (push) begin
            tx_mem[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            cycle_cnt_q   <= '0;
            snap_q        <= '0;
            io_rd_q       <= '0;
            rd_sel_ram_q  <= 1'b0;
            rx_ready_q    <= 1'b0;
            sim_stop_q    <= 1'b0;
            tx_overflow_q <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            cycle_cnt_q   <= cycle_cnt_d;
            snap_q        <= snap_d;
            io_rd_q       <= io_rd_d;
            rd_sel_ram_q  <= rd_sel_ram_d;
            rx_ready_q    <= rx_ready_d;
            sim_stop_q    <= sim_stop_d;
            tx_overflow_q <= tx_overflow_d;
        end
    end

    assign mem_din        = rd_sel_ram_q ? ram_rd_q : io_rd_q;
    assign tx_valid       = (count_q != '0);
    assign tx_data        = tx_mem[rd_ptr_q];
    assign io_buffer_full = (count_q >= CNT_W'(TX_DEPTH - 1));
    assign rx_ready       = rx_ready_q;
    assign sim_stop       = sim_stop_q;
    assign tx_overflow    = tx_overflow_q;

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed bench for mem_io_responder: vector table for RAM/RX reads plus hand
// sequences for the TX FIFO, full boundary, counter snapshot, stop flag and reset.
module tb_mem_io_responder;
    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic [31:0] mem_a;
    logic [7:0]  mem_dout;
    logic        mem_wr;
    logic [7:0]  mem_din;
    logic        io_buffer_full;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        sim_stop;
    logic        tx_overflow;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] cnt_model;

    typedef struct {
        logic        rdy;
        logic [31:0] addr;
        logic        wr;
        logic [7:0]  dout;
        logic        rxv;
        logic [7:0]  rxd;
        logic        chk_din;
        logic [7:0]  exp_din;
        logic        exp_rxr;
    } vec_t;

    vec_t vecs [12];

    mem_io_responder #(.ADDR_WIDTH(17), .TX_DEPTH(8)) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .mem_a          (mem_a),
        .mem_dout       (mem_dout),
        .mem_wr         (mem_wr),
        .mem_din        (mem_din),
        .io_buffer_full (io_buffer_full),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rx_ready       (rx_ready),
        .sim_stop       (sim_stop),
        .tx_overflow    (tx_overflow)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before 200000");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // One clock edge; the counter model advances on every non-stalled edge.
    task automatic stepClock();
        @(posedge clk_in);
        if (rdy_in && !rst_in) cnt_model++;
        #1;
    endtask

    task automatic applyStimulus(input logic rdy, input logic [31:0] addr,
                                 input logic wr, input logic [7:0] dout);
        rdy_in   = rdy;
        mem_a    = addr;
        mem_wr   = wr;
        mem_dout = dout;
        stepClock();
    endtask

    initial begin
        logic [7:0]  drain_exp [8];
        logic [31:0] held;
        int          guard;

        rst_in    = 1'b1;
        rdy_in    = 1'b1;
        mem_a     = 32'h0;
        mem_dout  = 8'h00;
        mem_wr    = 1'b0;
        tx_ready  = 1'b0;
        rx_data   = 8'h00;
        rx_valid  = 1'b0;
        cnt_model = 32'd0;

        vecs[0]  = '{1'b1, 32'h00010, 1'b1, 8'hA5, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[1]  = '{1'b1, 32'h1FFFF, 1'b1, 8'h3C, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[2]  = '{1'b1, 32'h00010, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'hA5, 1'b0};
        vecs[3]  = '{1'b1, 32'h1FFFF, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h3C, 1'b0};
        vecs[4]  = '{1'b0, 32'h00010, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h3C, 1'b0};
        vecs[5]  = '{1'b0, 32'h30000, 1'b0, 8'h00, 1'b1, 8'h31, 1'b1, 8'h3C, 1'b0};
        vecs[6]  = '{1'b1, 32'h30000, 1'b0, 8'h00, 1'b1, 8'h31, 1'b1, 8'h31, 1'b1};
        vecs[7]  = '{1'b1, 32'h30000, 1'b0, 8'h00, 1'b0, 8'h31, 1'b1, 8'h00, 1'b0};
        vecs[8]  = '{1'b1, 32'h30003, 1'b0, 8'h00, 1'b1, 8'h99, 1'b1, 8'h00, 1'b0};
        vecs[9]  = '{1'b1, 32'h00010, 1'b1, 8'h5A, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[10] = '{1'b1, 32'h00010, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h5A, 1'b0};
        vecs[11] = '{1'b1, 32'h30001, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0};

        repeat (3) @(posedge clk_in);
        #1;
        rst_in    = 1'b0;
        cnt_model = 32'd0;

        checkOutput("reset mem_din", mem_din, 8'h00);
        checkOutput("reset tx_valid", tx_valid, 1'b0);
        checkOutput("reset io_buffer_full", io_buffer_full, 1'b0);
        checkOutput("reset sim_stop", sim_stop, 1'b0);
        checkOutput("reset tx_overflow", tx_overflow, 1'b0);
        checkOutput("reset rx_ready", rx_ready, 1'b0);

        // RAM and RX vectors
        for (int i = 0; i < 12; i++) begin
            rx_valid = vecs[i].rxv;
            rx_data  = vecs[i].rxd;
            applyStimulus(vecs[i].rdy, vecs[i].addr, vecs[i].wr, vecs[i].dout);
            if (vecs[i].chk_din)
                checkOutput($sformatf("vec%0d mem_din", i), mem_din, vecs[i].exp_din);
            checkOutput($sformatf("vec%0d rx_ready", i), rx_ready, vecs[i].exp_rxr);
        end
        rx_valid = 1'b0;

        // TX path: zero byte and unused offset must not push
        applyStimulus(1'b1, 32'h30002, 1'b1, 8'h55);
        checkOutput("tx other offset ignored", tx_valid, 1'b0);
        applyStimulus(1'b1, 32'h30000, 1'b1, 8'h48);
        checkOutput("tx valid after push", tx_valid, 1'b1);
        applyStimulus(1'b1, 32'h30000, 1'b1, 8'h00);
        applyStimulus(1'b1, 32'h30000, 1'b1, 8'h69);
        applyStimulus(1'b1, 32'h00000, 1'b0, 8'h00);
        checkOutput("tx head H", tx_data, 8'h48);
        checkOutput("tx two not full", io_buffer_full, 1'b0);
        tx_ready = 1'b1;
        stepClock();
        checkOutput("tx second valid", tx_valid, 1'b1);
        checkOutput("tx head i", tx_data, 8'h69);
        stepClock();
        checkOutput("tx drained", tx_valid, 1'b0);
        tx_ready = 1'b0;

        // Full boundary
        for (int i = 1; i <= 7; i++) begin
            applyStimulus(1'b1, 32'h30000, 1'b1, 8'(i));
            checkOutput($sformatf("full after push %0d", i), io_buffer_full, (i >= 7) ? 1'b1 : 1'b0);
        end
        applyStimulus(1'b1, 32'h30000, 1'b1, 8'h08);
        checkOutput("8th push full", io_buffer_full, 1'b1);
        checkOutput("8th push no overflow", tx_overflow, 1'b0);
        tx_ready = 1'b1;
        applyStimulus(1'b1, 32'h30000, 1'b1, 8'h0A);
        tx_ready = 1'b0;
        checkOutput("push+pop at full no overflow", tx_overflow, 1'b0);
        checkOutput("push+pop at full still full", io_buffer_full, 1'b1);
        checkOutput("push+pop head", tx_data, 8'h02);
        applyStimulus(1'b1, 32'h30000, 1'b1, 8'h09);
        checkOutput("9th push overflow", tx_overflow, 1'b1);
        applyStimulus(1'b1, 32'h00000, 1'b0, 8'h00);
        drain_exp = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h0A};
        tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("drain%0d valid", i), tx_valid, 1'b1);
            checkOutput($sformatf("drain%0d data", i), tx_data, drain_exp[i]);
            stepClock();
        end
        checkOutput("drain empty", tx_valid, 1'b0);
        checkOutput("drain not full", io_buffer_full, 1'b0);
        tx_ready = 1'b0;

        // Counter snapshot across the 0xFF->0x100 carry
        guard = 0;
        while (cnt_model != 32'hFF && guard < 1000) begin
            applyStimulus(1'b1, 32'h00000, 1'b0, 8'h00);
            guard++;
        end
        checkOutput("counter reached 0xFF", cnt_model, 32'hFF);
        applyStimulus(1'b1, 32'h30004, 1'b0, 8'h00);
        checkOutput("cnt byte0", mem_din, 8'hFF);
        applyStimulus(1'b1, 32'h30005, 1'b0, 8'h00);
        checkOutput("cnt byte1", mem_din, 8'h00);
        applyStimulus(1'b1, 32'h30006, 1'b0, 8'h00);
        checkOutput("cnt byte2", mem_din, 8'h00);
        applyStimulus(1'b1, 32'h30007, 1'b0, 8'h00);
        checkOutput("cnt byte3", mem_din, 8'h00);

        // Stall freezes the counter and holds mem_din
        held = cnt_model;
        applyStimulus(1'b1, 32'h30004, 1'b0, 8'h00);
        checkOutput("cnt before stall", mem_din, held[7:0]);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 32'h30004, 1'b0, 8'h00);
        checkOutput("mem_din held in stall", mem_din, held[7:0]);
        held = cnt_model;
        applyStimulus(1'b1, 32'h30004, 1'b0, 8'h00);
        checkOutput("cnt after stall", mem_din, held[7:0]);
        applyStimulus(1'b1, 32'h30005, 1'b0, 8'h00);
        checkOutput("cnt after stall byte1", mem_din, held[15:8]);

        // Stop write, then reset mid-drain
        applyStimulus(1'b1, 32'h30004, 1'b1, 8'h77);
        checkOutput("stop flag", sim_stop, 1'b1);
        checkOutput("stop tx_valid", tx_valid, 1'b1);
        checkOutput("stop tx_data", tx_data, 8'h00);
        applyStimulus(1'b1, 32'h30000, 1'b1, 8'h41);
        tx_ready = 1'b1;
        applyStimulus(1'b1, 32'h00010, 1'b0, 8'h00);
        checkOutput("stop sticky", sim_stop, 1'b1);
        checkOutput("mid-drain head", tx_data, 8'h41);
        checkOutput("pre-reset mem_din", mem_din, 8'h5A);
        #2;
        rst_in = 1'b1;
        #1;
        checkOutput("async reset tx_valid", tx_valid, 1'b0);
        checkOutput("async reset sim_stop", sim_stop, 1'b0);
        checkOutput("async reset mem_din", mem_din, 8'h00);
        checkOutput("async reset tx_overflow", tx_overflow, 1'b0);
        checkOutput("async reset io_buffer_full", io_buffer_full, 1'b0);
        tx_ready = 1'b0;
        stepClock();
        rst_in    = 1'b0;
        cnt_model = 32'd0;
        applyStimulus(1'b1, 32'h00010, 1'b0, 8'h00);
        checkOutput("RAM kept over reset", mem_din, 8'h5A);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_io_responder.md
# mem_io_responder

Memory-side responder for the CPU's byte-wide memory bus (`mem_a`/`mem_dout`/`mem_wr` in, `mem_din` out). It holds the 128 KB program/data RAM and decodes the I/O window at `mem_a[17:16]==2'b11`:
- UART RX byte read
- UART TX byte write through a buffered FIFO that drives `io_buffer_full`
- a free-running cycle counter
- the program-stop flag

It sits between the CPU top and the UART/simulation harness and is the simulation and FPGA counterpart of the CPU's bus master.

## Interface
Parameters:
- `ADDR_WIDTH`, 17 — RAM holds 2^ADDR_WIDTH bytes, indexed by `mem_a[ADDR_WIDTH-1:0]`.
- `TX_DEPTH`, 8 — TX FIFO entries; power of two, ≥4.

Ports:
- `clk_in` in 1 — single clock.
- `rst_in` in 1 — reset, asynchronous, active-high.
- `rdy_in` in 1 — bus-side stall; low freezes all bus-side state.
- `mem_a` in 32 — address from CPU.
- `mem_dout` in 8 — write data from CPU.
- `mem_wr` in 1 — 1 = write, 0 = read.
- `mem_din` out 8 — read data to CPU, registered.
- `io_buffer_full` out 1 — TX FIFO almost full.
- `tx_data` out 8 — FIFO head byte.
- `tx_valid` out 1 — FIFO non-empty.
- `tx_ready` in 1 — UART accepts head this cycle.
- `rx_data` in 8 — UART received byte.
- `rx_valid` in 1 — `rx_data` valid.
- `rx_ready` out 1 — one-cycle pop pulse to UART RX.
- `sim_stop` out 1 — sticky program-stop flag.
- `tx_overflow` out 1 — sticky; a push was dropped on full.

## Operation
- Decode: `io = (mem_a[17:16]==2'b11)`; I/O offset = `mem_a[2:0]`. Non-io addresses go to RAM.
- Bus cycle definitions:
  - A bus cycle is any cycle with `rdy_in=1`.
  - `mem_wr=1` is a write.
  - `mem_wr=0` is a read. Every non-write cycle is a read, so the CPU idles on a RAM address.
- RAM write: on a write to a non-io address, the byte `mem_dout` is stored at `mem_a[ADDR_WIDTH-1:0]`.
- RAM read: on the next edge, `mem_din` ← the stored byte.
- IO read, offset 0:
  - `rx_valid=1`: `mem_din` ← `rx_data`, and `rx_ready` pulses for 1 cycle.
  - `rx_valid=0`: `mem_din` ← 0x00, no pulse.
- IO read, offset 4: snapshot register ← `cycle_cnt`; `mem_din` ← `cycle_cnt[7:0]`.
- IO read, offsets 5/6/7: `mem_din` ← snapshot byte 1/2/3. The snapshot is not updated, so a 4-byte read is coherent.
- IO write, offset 0:
  - `mem_dout`≠0: push `mem_dout` into the TX FIFO.
  - `mem_dout`=0x00: ignored.
- IO write, offset 4: `sim_stop` ← 1 and push 0x00 into the TX FIFO.
- Other io offsets: reads return 0x00; writes are ignored.
- Cycle counter: `cycle_cnt` is 32 bits and increments by 1 every cycle with `rdy_in=1`. It wraps 0xFFFFFFFF→0.
- TX FIFO:
  - Circular buffer with read/write pointers of log2(`TX_DEPTH`) bits and a count of log2(`TX_DEPTH`)+1 bits.
  - `tx_valid` = count≠0; `tx_data` = head.
  - Pop when `tx_valid && tx_ready`. Pop is independent of `rdy_in`.
  - Push and pop in the same cycle: count unchanged, both pointers advance. This is legal at full, because the pop frees a slot first.
  - Push when full and no pop: the byte is dropped and `tx_overflow` ← 1.
- `io_buffer_full` = (count ≥ `TX_DEPTH`-1). This is combinational from count and leaves one slot of slack for a write already in flight.
- `rdy_in=0`:
  - no RAM write, no push, no counter increment, no snapshot update;
  - `mem_din` holds its value;
  - `rx_ready`=0;
  - the TX drain continues.
- Reset, asynchronous, may arrive mid-operation:
  - `mem_din`=0, `rx_ready`=0, `sim_stop`=0, `tx_overflow`=0;
  - `cycle_cnt`=0, snapshot=0;
  - FIFO emptied, so `tx_valid`=0 and `io_buffer_full`=0.
  - RAM contents are not cleared.

## Timing
- Read latency is exactly 1 cycle: address presented at edge t gives `mem_din` valid after edge t+1.
- Writes take effect at the same edge. A RAM read at t+1 of the address written at t returns the new byte.
- `rx_ready` is registered and is high only in the cycle after the consuming read. The UART drops the byte at that edge.
- A TX push at edge t makes `tx_valid` rise after edge t when the FIFO was empty.
- `io_buffer_full` reflects the count after each edge.
- `sim_stop` rises the cycle after the stop write and never falls until reset.

## Test plan
- **RAM write/read:** write 0xA5 to 0x00010, then read 0x00010 → `mem_din`=0xA5 one cycle later. Then read 0x1FFFF (initialised 0x3C) → 0x3C.
- **TX path:**
  - Stimulus: with `tx_ready`=0, write 'H' (0x48), then 0x00, then 'i' (0x69) to 0x30000.
  - Check: count=2.
  - Stimulus: raise `tx_ready`.
  - Check: `tx_data` sequence 0x48, 0x69; `tx_valid` then drops.
- **Full boundary:**
  - Stimulus: `tx_ready`=0, `TX_DEPTH`=8; push 7 bytes.
  - Check: `io_buffer_full`=1 after the 7th push.
  - Stimulus: 8th push.
  - Check: accepted.
  - Stimulus: 9th push.
  - Check: dropped, `tx_overflow`=1.
  - Stimulus: push with simultaneous pop at full.
  - Check: count stays 8, no overflow.
- **RX path:**
  - Stimulus: `rx_valid`=1, `rx_data`=0x31; read 0x30000.
  - Check: `mem_din`=0x31 and a single `rx_ready` pulse.
  - Stimulus: read again with `rx_valid`=0.
  - Check: 0x00, no pulse.
- **Counter:**
  - Stimulus: force `cycle_cnt`=0x0000_00FF, then read 0x30004–0x30007 on consecutive cycles.
  - Check: 0xFF, 0x00, 0x00, 0x00, i.e. the snapshot despite carry.
  - Stimulus: `rdy_in`=0 for 5 cycles.
  - Check: counter unchanged.
- **Stop and reset:**
  - Stimulus: write any byte to 0x30004.
  - Check: `sim_stop`=1 and 0x00 emitted on `tx_data`.
  - Stimulus: assert `rst_in` mid-drain.
  - Check: `tx_valid`, `sim_stop`, `mem_din` all 0 immediately.
